// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display formatter.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Enough BCD digits to hold any 32-bit unsigned value.
    localparam int BCD_DIGITS = 10;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low seven-segment pattern, with forced blank.
module seg7_encode
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : SEG_TABLE[nibble];

endmodule

// File: rtl/display_formatter.sv
// Formats a 32-bit CPU display word onto eight HEX displays, in hex or in
// unsigned decimal via a bit-serial double-dabble engine; outputs update atomically.
module display_formatter
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       value,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS*7-1:0] segs,
    output logic                    busy,
    output logic                    overflow
);

    localparam int BCD_W = 4 * BCD_DIGITS;

    state_t state_reg, state_next;

    logic                    pending_reg;
    logic [DATA_W-1:0]       last_value_reg;
    logic                    last_mode_reg;
    logic                    last_lz_reg;
    logic [DATA_W-1:0]       bin_sr_reg;
    logic [BCD_W-1:0]        bcd_sr_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [NUM_DIGITS*7-1:0] segs_reg;
    logic                    busy_reg;
    logic                    overflow_reg;

    logic                    change;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+DATA_W-1:0] dd_next;
    logic [3:0]              dig_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dig_blank;
    logic [NUM_DIGITS:1]     zero_above;
    logic [6:0]              dig_seg [NUM_DIGITS];
    logic [NUM_DIGITS*7-1:0] seg_word;
    logic                    ovf_next;

    assign change = pending_reg
                 || (value    != last_value_reg)
                 || (dec_mode != last_mode_reg)
                 || (blank_lz != last_lz_reg);

    // Double-dabble step: add-3 correction on every digit, then a joint left shift.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_sr_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_sr_reg[4*gi +: 4] + 4'd3
                                      : bcd_sr_reg[4*gi +: 4];
        end
    endgenerate

    assign dd_next  = {bcd_adj, bin_sr_reg} << 1;
    assign ovf_next = last_mode_reg && (|bcd_sr_reg[BCD_W-1:4*NUM_DIGITS]);

    // zero_above[i] is set when digits i..NUM_DIGITS-1 are all zero.
    assign zero_above[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign dig_nib[gi] = last_mode_reg ? bcd_sr_reg[4*gi +: 4]
                                               : last_value_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign dig_blank[gi] = 1'b0;
            end else begin : g_upper
                assign zero_above[gi] = zero_above[gi+1] && (dig_nib[gi] == 4'd0);
                assign dig_blank[gi]  = last_lz_reg && zero_above[gi];
            end

            seg7_encode u_enc (
                .nibble (dig_nib[gi]),
                .blank  (dig_blank[gi]),
                .seg    (dig_seg[gi])
            );

            assign seg_word[7*gi +: 7] = ovf_next ? SEG_DASH : dig_seg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (change) state_next = dec_mode ? SHIFT : DONE;
            SHIFT:   if (cnt_reg == CNT_W'(DATA_W-1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg    <= 1'b1;
            last_value_reg <= '0;
            last_mode_reg  <= 1'b0;
            last_lz_reg    <= 1'b0;
            bin_sr_reg     <= '0;
            bcd_sr_reg     <= '0;
            cnt_reg        <= '0;
            segs_reg       <= '1;
            busy_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (change) begin
                        last_value_reg <= value;
                        last_mode_reg  <= dec_mode;
                        last_lz_reg    <= blank_lz;
                        pending_reg    <= 1'b0;
                        busy_reg       <= 1'b1;
                        bin_sr_reg     <= value;
                        bcd_sr_reg     <= '0;
                        cnt_reg        <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_sr_reg, bin_sr_reg} <= dd_next;
                    cnt_reg                  <= cnt_reg + 1'b1;
                end
                DONE: begin
                    segs_reg     <= seg_word;
                    overflow_reg <= ovf_next;
                    busy_reg     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign segs     = segs_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_display_formatter.sv
// Self-checking bench for display_formatter: directed corner cases plus random
// conversions checked against an arithmetic reference model.
module tb_display_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] value;
    logic        dec_mode;
    logic        blank_lz;
    logic [55:0] segs;
    logic        busy;
    logic        overflow;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    display_formatter #(.NUM_DIGITS(8), .DATA_W(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .dec_mode (dec_mode),
        .blank_lz (blank_lz),
        .segs     (segs),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: digits from plain division / nibble extraction.
    function automatic logic [55:0] model_segs(input logic [31:0] v, input logic dm, input logic lz);
        int                d [8];
        int                msd;
        longint unsigned   vv;
        longint unsigned   p;
        logic [55:0]       r;
        vv  = v;
        p   = 1;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            if (dm) begin
                d[i] = int'((vv / p) % 10);
                p    = p * 10;
            end else begin
                d[i] = int'(v[4*i +: 4]);
            end
        end
        if (dm && vv > 64'd99999999) return {8{7'h3F}};
        for (int i = 0; i < 8; i++) if (d[i] != 0) msd = i;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = (lz && i > msd) ? 7'h7F : SEG_REF[d[i]];
        return r;
    endfunction

    function automatic logic model_ovf(input logic [31:0] v, input logic dm);
        return dm && (v > 32'd99999999);
    endfunction

    // Inputs are already applied; waits for the conversion and checks its window.
    task automatic run_conv(input string tag);
        logic [55:0] old_segs;
        int          busy_cnt;
        bit          done;
        bit          stable;
        int          exp_lat;
        old_segs = segs;
        busy_cnt = 0;
        done     = 0;
        stable   = 1;
        exp_lat  = dec_mode ? 33 : 1;
        for (int c = 0; c < 60 && !done; c++) begin
            tick();
            if (busy) begin
                busy_cnt++;
                if (segs !== old_segs) stable = 0;
            end else begin
                done = 1;
            end
        end
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_lat));
        check({tag, "_hold"}, 64'(stable), 64'd1);
        check({tag, "_segs"}, 64'(segs), 64'(model_segs(value, dec_mode, blank_lz)));
        check({tag, "_ovf"}, 64'(overflow), 64'(model_ovf(value, dec_mode)));
        $display("conv %s value=%0d (0x%h) dec=%0b lz=%0b busy_edges=%0d segs=%h ovf=%0b",
                 tag, value, value, dec_mode, blank_lz, busy_cnt, segs, overflow);
    endtask

    initial begin
        logic [55:0] prev_segs;
        logic [55:0] first_segs;
        int          changes;
        logic [31:0] nv;
        logic        nd;
        logic        nl;

        // Reset and the pending conversion that follows release.
        rst_n    = 1'b0;
        value    = 32'd0;
        dec_mode = 1'b0;
        blank_lz = 1'b1;
        tick();
        tick();
        check("rst_segs", 64'(segs), 64'({8{7'h7F}}));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy), 64'd1);
        tick();
        check("post_rst_segs", 64'(segs), 64'({{7{7'h7F}}, 7'h40}));
        check("post_rst_busy_low", 64'(busy), 64'd0);
        check("post_rst_ovf", 64'(overflow), 64'd0);
        $display("conv reset_pending segs=%h", segs);

        // Hex mode.
        value    = 32'hDEADBEEF;
        blank_lz = 1'b0;
        run_conv("hex_deadbeef");
        check("hex_literal", 64'(segs),
              64'({7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));

        // Decimal mode.
        value    = 32'd12345678;
        dec_mode = 1'b1;
        run_conv("dec_12345678");
        check("dec_literal", 64'(segs),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

        value    = 32'd42;
        blank_lz = 1'b1;
        run_conv("dec_42_lz");

        value = 32'd100000000;
        run_conv("dec_ovf");
        value = 32'd99999999;
        run_conv("dec_max");

        // Value changes mid-conversion: old result first, then newest value.
        value    = 32'd5;
        blank_lz = 1'b0;
        tick();
        repeat (10) tick();
        value     = 32'd7;
        prev_segs = segs;
        first_segs = segs;
        changes   = 0;
        for (int c = 0; c < 90; c++) begin
            tick();
            if (segs !== prev_segs) begin
                changes++;
                if (changes == 1) first_segs = segs;
                prev_segs = segs;
            end
        end
        check("midchg_first", 64'(first_segs), 64'(model_segs(32'd5, 1'b1, 1'b0)));
        check("midchg_final", 64'(segs), 64'(model_segs(32'd7, 1'b1, 1'b0)));
        check("midchg_count", 64'(changes), 64'd2);
        check("midchg_busy", 64'(busy), 64'd0);
        $display("conv midchange 5->7 changes=%0d segs=%h", changes, segs);

        // Reset during SHIFT discards the partial result; pending restarts it.
        value = 32'd12345678;
        tick();
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_segs", 64'(segs), 64'({8{7'h7F}}));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        run_conv("after_midrst");

        // Random conversions.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       nv = $urandom;
                1:       nv = $urandom_range(0, 99999999);
                2:       nv = $urandom_range(0, 999);
                default: nv = 32'd99999990 + $urandom_range(0, 20);
            endcase
            nd = 1'($urandom_range(0, 1));
            nl = 1'($urandom_range(0, 1));
            if (nv == value && nd == dec_mode && nl == blank_lz) nv = nv ^ 32'd1;
            value    = nv;
            dec_mode = nd;
            blank_lz = nl;
            run_conv($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
